// File: rtl/get_legendre_mul_pkg.sv
// rtl/get_legendre_mul_pkg.sv - shared widths, fit modes and P_WIDTH range helpers
package get_legendre_mul_pkg;

  typedef enum logic {
    FIT_WRAP = 1'b0,
    FIT_SAT  = 1'b1
  } fit_mode_e;

  // Wide enough to hold any product plus a sign bit for comparisons.
  localparam int RANGE_W   = 136;
  localparam int MAX_STAGE = 8;

  function automatic int full_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  function automatic logic signed [RANGE_W-1:0] range_max(input bit is_signed, input int p_w);
    logic signed [RANGE_W-1:0] one;
    one = {{(RANGE_W-1){1'b0}}, 1'b1};
    return is_signed ? (one <<< (p_w - 1)) - one : (one <<< p_w) - one;
  endfunction

  function automatic logic signed [RANGE_W-1:0] range_min(input bit is_signed, input int p_w);
    logic signed [RANGE_W-1:0] one;
    one = {{(RANGE_W-1){1'b0}}, 1'b1};
    return is_signed ? -(one <<< (p_w - 1)) : '0;
  endfunction

endpackage

// File: rtl/get_legendre_segment_barrel_mul_fit.sv
// rtl/get_legendre_segment_barrel_mul_fit.sv - post-shift, overflow detect and wrap/saturate
module get_legendre_segment_barrel_mul_fit
  import get_legendre_mul_pkg::*;
#(
  parameter int        FULL_W     = 44,
  parameter int        P_WIDTH    = 32,
  parameter int        SIGNED_RES = 0,
  parameter int        SHIFT      = 0,
  parameter fit_mode_e MODE       = FIT_WRAP
) (
  input  logic [FULL_W-1:0]  full_i,
  output logic [P_WIDTH-1:0] p_o,
  output logic               ovf_o
);

  localparam bit IS_S = (SIGNED_RES != 0);
  localparam logic signed [RANGE_W-1:0] P_MAX = range_max(IS_S, P_WIDTH);
  localparam logic signed [RANGE_W-1:0] P_MIN = range_min(IS_S, P_WIDTH);

  logic [FULL_W-1:0]         s;
  logic signed [RANGE_W-1:0] s_ext;
  logic                      over_hi;
  logic                      under_lo;

  always_comb begin
    if (IS_S) begin
      s = $signed(full_i) >>> SHIFT;
    end else begin
      s = full_i >> SHIFT;
    end
    s_ext = {{(RANGE_W-FULL_W){IS_S & s[FULL_W-1]}}, s};
  end

  generate
    if (P_WIDTH >= FULL_W) begin : g_fits
      assign over_hi  = 1'b0;
      assign under_lo = 1'b0;
    end else begin : g_narrow
      assign over_hi  = s_ext > P_MAX;
      assign under_lo = s_ext < P_MIN;
    end
  endgenerate

  assign ovf_o = over_hi | under_lo;

  always_comb begin
    p_o = s_ext[P_WIDTH-1:0];
    if (MODE == FIT_SAT) begin
      if (over_hi) begin
        p_o = P_MAX[P_WIDTH-1:0];
      end else if (under_lo) begin
        p_o = P_MIN[P_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/get_legendre_segment_barrel_mul_pipe.sv
// rtl/get_legendre_segment_barrel_mul_pipe.sv - pipelined multiplier with valid/ready and tag
module get_legendre_segment_barrel_mul_pipe
  import get_legendre_mul_pkg::*;
#(
  parameter int A_WIDTH   = 26,
  parameter int B_WIDTH   = 18,
  parameter int P_WIDTH   = 32,
  parameter int NUM_STAGE = 3,
  parameter int SIGNED_A  = 0,
  parameter int SIGNED_B  = 0,
  parameter int SHIFT     = 0,
  parameter int SAT       = 0,
  parameter int TAG_WIDTH = 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [B_WIDTH-1:0]   in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [P_WIDTH-1:0]   out_p,
  output logic                 out_ovf,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int        FW   = full_width(A_WIDTH, B_WIDTH);
  localparam int        NS   = NUM_STAGE;
  localparam int        SRES = ((SIGNED_A != 0) || (SIGNED_B != 0)) ? 1 : 0;
  localparam fit_mode_e MODE = (SAT != 0) ? FIT_SAT : FIT_WRAP;

  logic [NS-1:0]        v_q;
  logic [NS-1:0]        v_d;
  logic [NS-1:0]        adv;
  logic [NS-1:0]        ld;
  logic [TAG_WIDTH-1:0] tag_q [NS];
  logic [FW-1:0]        a_ext;
  logic [FW-1:0]        b_ext;
  logic [FW-1:0]        prod;
  logic [FW-1:0]        fit_in;
  logic                 last_src_v;
  logic [P_WIDTH-1:0]   fit_p;
  logic                 fit_ovf;
  logic [P_WIDTH-1:0]   p_q;
  logic                 ovf_q;

  // Modulo-2^FW product of the extended operands is the exact two's complement result.
  assign a_ext = {{(FW-A_WIDTH){in_a[A_WIDTH-1] & (SIGNED_A != 0)}}, in_a};
  assign b_ext = {{(FW-B_WIDTH){in_b[B_WIDTH-1] & (SIGNED_B != 0)}}, in_b};
  assign prod  = a_ext * b_ext;

  // Bubble-collapsing: a stage may load whenever it is empty or its content moves on.
  always_comb begin
    adv      = '0;
    ld       = '0;
    v_d      = v_q;
    adv[NS-1] = out_ready;
    for (int i = NS - 2; i >= 0; i--) begin
      adv[i] = !v_q[i+1] || adv[i+1];
    end
    ld = ~v_q | adv;
    if (ld[0]) begin
      v_d[0] = in_valid;
    end
    for (int i = 1; i < NS; i++) begin
      if (ld[i]) begin
        v_d[i] = v_q[i-1];
      end
    end
  end

  assign in_ready = ld[0];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NS; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      if (in_valid && ld[0]) begin
        tag_q[0] <= in_tag;
      end
      for (int i = 1; i < NS; i++) begin
        if (ld[i] && v_q[i-1]) begin
          tag_q[i] <= tag_q[i-1];
        end
      end
    end
  end

  generate
    if (NS > 1) begin : g_deep
      logic [FW-1:0] full_q [NS-1];

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          for (int i = 0; i < NS - 1; i++) begin
            full_q[i] <= '0;
          end
        end else begin
          if (in_valid && ld[0]) begin
            full_q[0] <= prod;
          end
          for (int i = 1; i < NS - 1; i++) begin
            if (ld[i] && v_q[i-1]) begin
              full_q[i] <= full_q[i-1];
            end
          end
        end
      end

      assign fit_in     = full_q[NS-2];
      assign last_src_v = v_q[NS-2];
    end else begin : g_single
      assign fit_in     = prod;
      assign last_src_v = in_valid;
    end
  endgenerate

  get_legendre_segment_barrel_mul_fit #(
    .FULL_W    (FW),
    .P_WIDTH   (P_WIDTH),
    .SIGNED_RES(SRES),
    .SHIFT     (SHIFT),
    .MODE      (MODE)
  ) u_fit (
    .full_i(fit_in),
    .p_o   (fit_p),
    .ovf_o (fit_ovf)
  );

  // Final stage only loads when it can advance, so a stalled result holds still.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      p_q   <= '0;
      ovf_q <= 1'b0;
    end else if (ld[NS-1] && last_src_v) begin
      p_q   <= fit_p;
      ovf_q <= fit_ovf;
    end
  end

  assign out_valid = v_q[NS-1];
  assign out_p     = p_q;
  assign out_ovf   = ovf_q;
  assign out_tag   = tag_q[NS-1];

endmodule

// File: tb/tb_get_legendre_segment_barrel_mul_pipe.sv
// tb/tb_get_legendre_segment_barrel_mul_pipe.sv - scoreboard bench over five parameter sets
module tb_get_legendre_segment_barrel_mul_pipe;

  localparam int ND = 5;
  localparam int NS = 3;

  typedef struct packed {
    logic [31:0] p;
    logic        ovf;
    logic [7:0]  tag;
  } exp_t;

  int cfg_sa  [ND] = '{0, 0, 1, 1, 0};
  int cfg_sb  [ND] = '{0, 0, 1, 1, 0};
  int cfg_sh  [ND] = '{0, 0, 0, 0, 4};
  int cfg_sat [ND] = '{0, 1, 0, 1, 0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [25:0] in_a;
  logic [17:0] in_b;
  logic [7:0]  in_tag;
  logic        in_rdy  [ND];
  logic        o_valid [ND];
  logic [31:0] o_p     [ND];
  logic        o_ovf   [ND];
  logic [7:0]  o_tag   [ND];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   lat_chk;
  bit   rand_rdy;
  exp_t q [ND][$];
  int   acc_q [$];

  always #5 clk = ~clk;

  get_legendre_segment_barrel_mul_pipe #(.SAT(0)) u_d0 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[0]),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(o_valid[0]), .out_ready(out_ready),
    .out_p(o_p[0]), .out_ovf(o_ovf[0]), .out_tag(o_tag[0]));
  get_legendre_segment_barrel_mul_pipe #(.SAT(1)) u_d1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[1]),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(o_valid[1]), .out_ready(out_ready),
    .out_p(o_p[1]), .out_ovf(o_ovf[1]), .out_tag(o_tag[1]));
  get_legendre_segment_barrel_mul_pipe #(.SIGNED_A(1), .SIGNED_B(1)) u_d2 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[2]),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(o_valid[2]), .out_ready(out_ready),
    .out_p(o_p[2]), .out_ovf(o_ovf[2]), .out_tag(o_tag[2]));
  get_legendre_segment_barrel_mul_pipe #(.SIGNED_A(1), .SIGNED_B(1), .SAT(1)) u_d3 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[3]),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(o_valid[3]), .out_ready(out_ready),
    .out_p(o_p[3]), .out_ovf(o_ovf[3]), .out_tag(o_tag[3]));
  get_legendre_segment_barrel_mul_pipe #(.SHIFT(4)) u_d4 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[4]),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(o_valid[4]), .out_ready(out_ready),
    .out_p(o_p[4]), .out_ovf(o_ovf[4]), .out_tag(o_tag[4]));

  function automatic exp_t model(int d, logic [25:0] a, logic [17:0] b, logic [7:0] tg);
    exp_t   m;
    longint av, bv, full, s, mx, mn;
    av   = (cfg_sa[d] != 0) ? longint'($signed(a)) : longint'(a);
    bv   = (cfg_sb[d] != 0) ? longint'($signed(b)) : longint'(b);
    full = av * bv;
    s    = full >>> cfg_sh[d];
    if (cfg_sa[d] != 0 || cfg_sb[d] != 0) begin
      mx = 64'sh7FFF_FFFF;
      mn = -64'sh8000_0000;
    end else begin
      mx = 64'sh FFFF_FFFF;
      mn = 64'sh0;
    end
    m.ovf = (s > mx) || (s < mn);
    m.p   = s[31:0];
    if (cfg_sat[d] != 0 && s > mx) m.p = mx[31:0];
    if (cfg_sat[d] != 0 && s < mn) m.p = mn[31:0];
    m.tag = tg;
    return m;
  endfunction

  task automatic chk(string nm, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int d = 0; d < ND; d++) n += q[d].size();
    return n;
  endfunction

  task automatic tick(output bit acc);
    exp_t e;
    int   t;
    @(negedge clk);
    acc = in_valid && in_rdy[0];
    for (int d = 0; d < ND; d++) begin
      if (acc) q[d].push_back(model(d, in_a, in_b, in_tag));
      if (o_valid[d] && out_ready) begin
        if (q[d].size() == 0) begin
          chk($sformatf("spurious_out_d%0d", d), o_valid[d], 1'b0);
        end else begin
          e = q[d].pop_front();
          chk($sformatf("p_d%0d_tag%0h", d, e.tag), o_p[d], e.p);
          chk($sformatf("ovf_d%0d_tag%0h", d, e.tag), o_ovf[d], e.ovf);
          chk($sformatf("tag_d%0d", d), o_tag[d], e.tag);
        end
      end else if (o_valid[d] && q[d].size() > 0) begin
        chk($sformatf("stall_p_d%0d", d), o_p[d], q[d][0].p);
        chk($sformatf("stall_tag_d%0d", d), o_tag[d], q[d][0].tag);
      end
    end
    if (acc) acc_q.push_back(cyc);
    if (o_valid[0] && out_ready && acc_q.size() > 0) begin
      t = acc_q.pop_front();
      if (lat_chk) chk("latency", cyc - t, NS);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(logic [25:0] a, logic [17:0] b, logic [7:0] tg);
    bit acc;
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = tg;
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("send_timeout", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    while (pending() > 0 && n < 200) begin
      tick(acc);
      n++;
    end
    chk("drain_pending", pending(), 0);
  endtask

  initial begin
    bit acc;
    int c0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    rand_rdy  = 1'b0;

    #12;
    for (int d = 0; d < ND; d++) begin
      chk("rst_out_valid", o_valid[d], 1'b0);
      chk("rst_out_p", o_p[d], 32'h0);
      chk("rst_out_ovf", o_ovf[d], 1'b0);
      chk("rst_out_tag", o_tag[d], 8'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", in_rdy[0], 1'b1);

    send(26'h3FF_FFFF, 18'h3_FFFF, 8'h11);  drain();
    send(26'd1000,     18'd3,      8'h22);  drain();
    send(26'h3FF_FFFD, 18'd5,      8'h33);  drain();
    send(26'h200_0000, 18'h2_0000, 8'h44);  drain();
    send(26'd100,      18'd7,      8'h55);  drain();

    c0 = cyc;
    for (int i = 0; i < 12; i++) send(26'($urandom), 18'($urandom), 8'(8'h60 + i));
    chk("throughput_cycles", cyc - c0, 12);
    drain();

    lat_chk  = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 16; i++) send(26'($urandom), 18'($urandom), 8'(8'hA0 + i));
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    drain();

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(26'(i + 5), 18'(i + 9), 8'(i));
    chk("in_ready_full", in_rdy[0], 1'b0);
    in_valid = 1'b1;
    in_a     = 26'd8;
    in_b     = 18'd12;
    in_tag   = 8'd3;
    for (int k = 0; k < 5; k++) begin
      tick(acc);
      chk("stall_no_accept", acc, 1'b0);
    end
    out_ready = 1'b1;
    c0 = 0;
    do begin
      tick(acc);
      c0++;
    end while (!acc && c0 < 20);
    chk("bp_accept_after_release", acc, 1'b1);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_consecutive_valid", o_valid[0], 1'b1);
      tick(acc);
    end
    drain();

    out_ready = 1'b0;
    send(26'd7, 18'd9, 8'h80);
    send(26'd6, 18'd4, 8'h81);
    tick(acc);
    chk("pre_reset_valid", o_valid[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("async_reset_valid", o_valid[d], 1'b0);
      q[d].delete();
    end
    acc_q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(acc);
      chk("post_reset_idle", o_valid[0], 1'b0);
    end
    lat_chk = 1'b1;
    send(26'd12345, 18'd321, 8'h90);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
